// File: rtl/ec_dec_renorm.sv
// Decoder-side renormaliser for the AV1 entropy decoder: owns rng/dif/cnt,
// normalises after each symbol and refills dif one bitstream byte per cycle.
//
// state | meaning
// IDLE  | waiting for start after reset
// FILL  | pulling bytes into dif until cnt covers the window or stream ends
// READY | rng/dif normalised, waiting for the next post-symbol request
// NORM  | one-cycle left shift of rng/dif by the leading-zero count of rng
module ec_dec_renorm #(
    parameter int              WIN  = 32,
    parameter int              CNTW = 16,
    parameter logic [CNTW-1:0] LOTS = 16'h4000
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [15:0]    req_rng_i,
    input  logic [WIN-1:0] req_dif_i,
    output logic           state_valid_o,
    output logic [15:0]    cur_rng_o,
    output logic [WIN-1:0] cur_dif_o,
    input  logic           bs_valid_i,
    output logic           bs_ready_o,
    input  logic [7:0]     bs_data_i,
    input  logic           bs_last_i,
    output logic           eos_o,
    output logic           err_o
);

    typedef enum logic [1:0] {IDLE, FILL, READY, NORM} state_t;

    localparam int                     WOFS     = WIN - 24;
    localparam logic signed [CNTW-1:0] WOFS_C   = CNTW'(WOFS);
    localparam logic [WIN-1:0]         DIF_INIT = {1'b0, {(WIN-1){1'b1}}};

    state_t                state_q;
    logic [15:0]           rng_q;
    logic [WIN-1:0]        dif_q;
    logic signed [CNTW-1:0] cnt_q;
    logic                  eos_q;
    logic                  err_q;

    logic                   fill_done;
    logic [5:0]             sh_amt;
    logic [WIN-1:0]         byte_sh;
    logic [3:0]             lz;
    logic [WIN-1:0]         dif_norm;
    logic signed [CNTW-1:0] cnt_norm;

    function automatic logic [3:0] lzc16(input logic [15:0] v);
        lzc16 = 4'd15;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) lzc16 = 4'(15 - i);
        end
    endfunction

    // s = WIN-24-cnt; s<0 exactly when cnt exceeds WIN-24. When s>=0 it is
    // at most WIN-9, so its low six bits are the whole shift amount.
    always_comb begin
        fill_done = (cnt_q > WOFS_C);
        sh_amt    = 6'(WOFS) - cnt_q[5:0];
        byte_sh   = {{(WIN-8){1'b0}}, bs_data_i} << sh_amt;
        lz        = lzc16(rng_q);
        dif_norm  = ((dif_q + WIN'(1)) << lz) - WIN'(1);
        cnt_norm  = cnt_q - $signed({{(CNTW-4){1'b0}}, lz});
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rng_q   <= 16'h8000;
            dif_q   <= DIF_INIT;
            cnt_q   <= '0;
            eos_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (start_i) begin
            state_q <= FILL;
            rng_q   <= 16'h8000;
            dif_q   <= DIF_INIT;
            cnt_q   <= -CNTW'(15);
            eos_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                FILL: begin
                    if (eos_q) begin
                        cnt_q   <= LOTS;
                        state_q <= READY;
                    end else if (fill_done) begin
                        state_q <= READY;
                    end else if (bs_valid_i) begin
                        dif_q <= dif_q ^ byte_sh;
                        if (bs_last_i) begin
                            eos_q <= 1'b1;
                            cnt_q <= LOTS;
                        end else begin
                            cnt_q <= cnt_q + CNTW'(8);
                        end
                    end
                end
                READY: begin
                    if (req_valid_i) begin
                        rng_q   <= req_rng_i;
                        dif_q   <= req_dif_i;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (rng_q == 16'h0000) begin
                        err_q   <= 1'b1;
                        state_q <= READY;
                    end else begin
                        rng_q   <= rng_q << lz;
                        dif_q   <= dif_norm;
                        cnt_q   <= cnt_norm;
                        state_q <= cnt_norm[CNTW-1] ? FILL : READY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_valid_o = (state_q == READY);
    assign req_ready_o   = state_valid_o;
    assign bs_ready_o    = (state_q == FILL) && !eos_q && !fill_done;
    assign cur_rng_o     = rng_q;
    assign cur_dif_o     = dif_q;
    assign eos_o         = eos_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ec_dec_renorm.sv
// Directed bench for ec_dec_renorm (WIN=32): table of post-symbol requests
// applied after a fixed init, plus hand sequences for stalls, eos and reset.
module tb_ec_dec_renorm;

    logic        clk = 1'b0;
    logic        reset, start, req_valid, req_ready;
    logic [15:0] req_rng;
    logic [31:0] req_dif;
    logic        state_valid;
    logic [15:0] cur_rng;
    logic [31:0] cur_dif;
    logic        bs_valid, bs_ready, bs_last, eos, err;
    logic [7:0]  bs_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ec_dec_renorm #(.WIN(32), .CNTW(16), .LOTS(16'h4000)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_rng_i(req_rng), .req_dif_i(req_dif),
        .state_valid_o(state_valid), .cur_rng_o(cur_rng), .cur_dif_o(cur_dif),
        .bs_valid_i(bs_valid), .bs_ready_o(bs_ready), .bs_data_i(bs_data),
        .bs_last_i(bs_last), .eos_o(eos), .err_o(err)
    );

    typedef struct {
        logic [15:0] rng;
        logic [31:0] dif;
        int          n;
        logic [23:0] bytes;
        logic [15:0] e_rng;
        logic [31:0] e_dif;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers up to n bytes (MSB byte first) until state_valid, bounded at 40 cycles.
    task automatic run_until_valid(input logic [23:0] bytes, input int n,
                                   output int cycles, output int consumed);
        bit acc;
        cycles   = 0;
        consumed = 0;
        while (!state_valid && cycles < 40) begin
            bs_valid = (consumed < n);
            case (consumed)
                0:       bs_data = bytes[23:16];
                1:       bs_data = bytes[15:8];
                default: bs_data = bytes[7:0];
            endcase
            acc = bs_valid && bs_ready;
            tick();
            cycles++;
            if (acc) consumed++;
        end
        bs_valid = 1'b0;
    endtask

    task automatic init_tile(output int cycles, output int consumed);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_valid(24'hA53CFF, 3, cycles, consumed);
    endtask

    task automatic apply_req(input logic [15:0] r, input logic [31:0] d);
        req_valid = 1'b1;
        req_rng   = r;
        req_dif   = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sv"},   64'(state_valid), 64'h0);
        check({tag, "_rr"},   64'(req_ready),   64'h0);
        check({tag, "_bsr"},  64'(bs_ready),    64'h0);
        check({tag, "_eos"},  64'(eos),         64'h0);
        check({tag, "_err"},  64'(err),         64'h0);
        check({tag, "_rng"},  64'(cur_rng),     64'h8000);
        check({tag, "_dif"},  64'(cur_dif),     64'h7FFFFFFF);
        check({tag, "_cnt"},  {48'h0, dut.cnt_q}, 64'h0);
    endtask

    initial begin
        int cyc, cons;

        vecs[0] = '{16'h8000, 32'h2D61807F, 0, 24'h0,      16'h8000, 32'h2D61807F, 16'd9};
        vecs[1] = '{16'h0001, 32'h2D61807F, 2, 24'h123400, 16'h8000, 32'hC03B72FF, 16'd10};
        vecs[2] = '{16'h4000, 32'h12345678, 0, 24'h0,      16'h8000, 32'h2468ACF1, 16'd8};
        vecs[3] = '{16'h00FF, 32'h0000FFFF, 0, 24'h0,      16'hFF00, 32'h00FFFFFF, 16'd1};
        vecs[4] = '{16'h0100, 32'hFFFFFFFF, 0, 24'h0,      16'h8000, 32'hFFFFFFFF, 16'd2};
        vecs[5] = '{16'h0050, 32'h80000000, 0, 24'h0,      16'hA000, 32'h000001FF, 16'd0};
        vecs[6] = '{16'h0028, 32'h00000000, 2, 24'hABCD00, 16'hA000, 32'h00015465, 16'd15};

        reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_rng = '0; req_dif = '0;
        bs_valid = 1'b0; bs_data = '0; bs_last = 1'b0;
        #1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_vals("rst");

        // Init from the three-byte preamble.
        init_tile(cyc, cons);
        check("init_cons", 64'(cons), 64'd3);
        check("init_cyc",  64'(cyc),  64'd4);
        check("init_sv",   64'(state_valid), 64'h1);
        check("init_rng",  64'(cur_rng), 64'h8000);
        check("init_dif",  64'(cur_dif), 64'h2D61807F);
        check("init_cnt",  {48'h0, dut.cnt_q}, 64'd9);

        // Table: fresh init, one request, then normalisation (+refill).
        for (int i = 0; i < 7; i++) begin
            init_tile(cyc, cons);
            check($sformatf("v%0d_rdy", i), 64'(req_ready), 64'h1);
            apply_req(vecs[i].rng, vecs[i].dif);
            check($sformatf("v%0d_drop", i), 64'(state_valid), 64'h0);
            run_until_valid(vecs[i].bytes, vecs[i].n, cyc, cons);
            check($sformatf("v%0d_cyc", i),  64'(cyc),
                  (vecs[i].n == 0) ? 64'd1 : 64'(vecs[i].n + 2));
            check($sformatf("v%0d_cons", i), 64'(cons), 64'(vecs[i].n));
            check($sformatf("v%0d_rng", i),  64'(cur_rng), 64'(vecs[i].e_rng));
            check($sformatf("v%0d_dif", i),  64'(cur_dif), 64'(vecs[i].e_dif));
            check($sformatf("v%0d_cnt", i),  {48'h0, dut.cnt_q}, 64'(vecs[i].e_cnt));
            check($sformatf("v%0d_err", i),  64'(err), 64'h0);
        end

        // Stream gap mid-refill; a request offered in FILL must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        bs_valid = 1'b1; bs_data = 8'hA5;
        tick();
        bs_valid = 1'b0;
        req_valid = 1'b1; req_rng = 16'h0001; req_dif = 32'h0;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("gap%0d_bsr", g), 64'(bs_ready), 64'h1);
            check($sformatf("gap%0d_sv", g),  64'(state_valid), 64'h0);
            check($sformatf("gap%0d_dif", g), 64'(cur_dif), 64'h2D7FFFFF);
            check($sformatf("gap%0d_cnt", g), {48'h0, dut.cnt_q}, 64'hFFF9);
            tick();
        end
        req_valid = 1'b0;
        run_until_valid(24'h3CFF00, 2, cyc, cons);
        check("gap_resume_cyc", 64'(cyc), 64'd3);
        check("gap_resume_dif", 64'(cur_dif), 64'h2D61807F);
        check("gap_resume_cnt", {48'h0, dut.cnt_q}, 64'd9);
        check("gap_resume_rng", 64'(cur_rng), 64'h8000);

        // End of stream on the first byte.
        start = 1'b1; tick(); start = 1'b0;
        bs_valid = 1'b1; bs_data = 8'hA5; bs_last = 1'b1;
        tick();
        bs_valid = 1'b0; bs_last = 1'b0;
        check("eos_flag", 64'(eos), 64'h1);
        check("eos_cnt",  {48'h0, dut.cnt_q}, 64'h4000);
        check("eos_dif",  64'(cur_dif), 64'h2D7FFFFF);
        check("eos_bsr",  64'(bs_ready), 64'h0);
        run_until_valid(24'h0, 0, cyc, cons);
        check("eos_exit_cyc", 64'(cyc), 64'd1);
        for (int r = 0; r < 3; r++) begin
            apply_req(16'h0001, 32'h0);
            check($sformatf("eos_n%0d_bsr", r), 64'(bs_ready), 64'h0);
            run_until_valid(24'hEEEEEE, 3, cyc, cons);
            check($sformatf("eos_n%0d_cyc", r),  64'(cyc),  64'd1);
            check($sformatf("eos_n%0d_cons", r), 64'(cons), 64'd0);
        end
        check("eos_cnt_after", {48'h0, dut.cnt_q}, 64'h3FD3);
        check("eos_rng_after", 64'(cur_rng), 64'h8000);

        // Reset in the middle of FILL.
        start = 1'b1; tick(); start = 1'b0;
        bs_valid = 1'b1; bs_data = 8'hA5;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; bs_valid = 1'b0;
        check_reset_vals("midrst");
        bs_valid = 1'b1;
        tick();
        bs_valid = 1'b0;
        check_reset_vals("idle");

        // Zero range request.
        init_tile(cyc, cons);
        apply_req(16'h0000, 32'h12345678);
        run_until_valid(24'h0, 0, cyc, cons);
        check("zero_cyc", 64'(cyc), 64'd1);
        check("zero_err", 64'(err), 64'h1);
        check("zero_rng", 64'(cur_rng), 64'h0000);
        check("zero_dif", 64'(cur_dif), 64'h12345678);
        check("zero_cnt", {48'h0, dut.cnt_q}, 64'd9);
        apply_req(16'h8000, 32'h0);
        run_until_valid(24'h0, 0, cyc, cons);
        check("zero_sticky", 64'(err), 64'h1);
        start = 1'b1; tick(); start = 1'b0;
        check("start_clr_err", 64'(err), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
